nibble_serial_adder: RTL

//  Multi-cycle WIDTH-bit adder/subtractor built around one cla_4bit instance
//  (ports a[3:0], b[3:0], cin, s[3:0], cout). Feeds one 4-bit slice per clock
//  LSB-first into the CLA, chaining carry through a register. Trades latency
//  for area. Sits between a valid/ready operand source and a valid/ready consumer.

---
 rtl/nibble_serial_adder.sv | 139 +++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
// Serial WIDTH-bit adder/subtractor: one 4-bit carry-lookahead slice per clock, LSB first.
// The carry between slices is held in a register, so one CLA instance serves every slice.

module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Flat lookahead carries, no ripple between bit positions
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s    = p ^ c[3:0];
    assign cout = c[4];
endmodule

module nibble_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry;
    logic             cout_r;
    logic             ovf_r;
    logic [IW-1:0]    idx;
    logic [IW+1:0]    base;
    logic             last;
    logic             accept;
    logic [3:0]       cla_s;
    logic             cla_cout;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign base      = {idx, 2'b00};
    assign last      = (idx == IW'(NIB - 1));
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

    cla_4bit u_cla (
        .a    (a_r[base +: 4]),
        .b    (b_r[base +: 4]),
        .cin  (carry),
        .s    (cla_s),
        .cout (cla_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Subtraction is folded into the operands at accept: invert B, force carry-in
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            idx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_r   <= a;
                        b_r   <= op_sub ? ~b : b;
                        carry <= op_sub ? 1'b1 : cin;
                        sum_r <= '0;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    sum_r[base +: 4] <= cla_s;
                    carry            <= cla_cout;
                    if (last) begin
                        cout_r <= cla_cout;
                        ovf_r  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (cla_s[3] != a_r[WIDTH-1]);
                        idx    <= '0;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
